// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle controller: opcodes, state
// encoding and the datapath select codes.
package mc_pkg;

   localparam logic [5:0] OP_R    = 6'd20;
   localparam logic [5:0] OP_ADDI = 6'd39;
   localparam logic [5:0] OP_SUBI = 6'd40;
   localparam logic [5:0] OP_SW   = 6'd41;
   localparam logic [5:0] OP_LW   = 6'd42;
   localparam logic [5:0] OP_BEQ  = 6'd25;
   localparam logic [5:0] OP_J    = 6'd26;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_RWB    = 4'd7,
      S_IEXEC  = 4'd8,
      S_IWB    = 4'd9,
      S_BRANCH = 4'd10,
      S_JUMP   = 4'd11,
      S_TRAP   = 4'd12
   } state_t;

   localparam logic [2:0] ALUOP_ADD   = 3'd0;
   localparam logic [2:0] ALUOP_SUB   = 3'd1;
   localparam logic [2:0] ALUOP_FUNCT = 3'd2;

   localparam logic [1:0] SRCB_REG    = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_next_state.sv
// Next-state function of the multi-cycle sequencer.
//
//  state  | meaning
//  FETCH  | read instruction, PC+4; leave on mem_ready & en
//  DECODE | branch target into ALUOut, dispatch on Op
//  MEMADR | compute load/store address
//  MEMRD  | data read, wait for mem_ready
//  MEMWB  | load writeback (retire)
//  MEMWR  | data write, wait for mem_ready (retire on ready)
//  EXEC   | R-type ALU operation
//  RWB    | R-type writeback (retire)
//  IEXEC  | ADDI/SUBI ALU operation
//  IWB    | immediate writeback (retire)
//  BRANCH | BEQ compare and conditional PC write (retire)
//  JUMP   | unconditional PC write (retire)
//  TRAP   | illegal opcode, held until reset
module mc_next_state
   import mc_pkg::*;
(
   input  state_t      state,
   input  logic [5:0]  op,
   input  logic        mem_ready,
   input  logic        en,
   output state_t      state_d
);

   // next-state selection; unused encodings fall back to FETCH
   always_comb begin
      state_d = S_FETCH;
      case (state)
         S_FETCH:  state_d = (mem_ready && en) ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW:     state_d = S_MEMADR;
               OP_R:             state_d = S_EXEC;
               OP_ADDI, OP_SUBI: state_d = S_IEXEC;
               OP_BEQ:           state_d = S_BRANCH;
               OP_J:             state_d = S_JUMP;
               default:          state_d = S_TRAP;
            endcase
         end
         S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWB:  state_d = S_FETCH;
         S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
         S_EXEC:   state_d = S_RWB;
         S_RWB:    state_d = S_FETCH;
         S_IEXEC:  state_d = S_IWB;
         S_IWB:    state_d = S_FETCH;
         S_BRANCH: state_d = S_FETCH;
         S_JUMP:   state_d = S_FETCH;
         S_TRAP:   state_d = S_TRAP;
         default:  state_d = S_FETCH;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle datapath controller: state register, output decode and
// retired-instruction counter. Outputs are a decode of the registered
// state, with mem_ready/en qualifying the FETCH writes and MEMWR retire.
module multicycle_control
   import mc_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [5:0]       Op,
   input  logic             mem_ready,
   output logic             PCWrite,
   output logic             PCWriteCond,
   output logic             IorD,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             MemtoReg,
   output logic             RegDst,
   output logic             RegWrite,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [2:0]       ALUOp,
   output logic [1:0]       PCSource,
   output logic             retire,
   output logic             illegal,
   output logic [3:0]       state_o,
   output logic [CNT_W-1:0] instr_count
);

   state_t           state_q, state_d, state_dec;
   logic [CNT_W-1:0] instr_count_q, instr_count_d;

   mc_next_state u_next (
      .state     (state_q),
      .op        (Op),
      .mem_ready (mem_ready),
      .en        (en),
      .state_d   (state_d)
   );

   // counter advances on every retire pulse, wrapping naturally
   always_comb begin
      instr_count_d = instr_count_q + {{(CNT_W-1){1'b0}}, retire};
   end

   // state and counter registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= S_FETCH;
         instr_count_q <= '0;
      end else begin
         state_q       <= state_d;
         instr_count_q <= instr_count_d;
      end
   end

   // while reset is held the outputs look like FETCH
   always_comb begin
      state_dec = rst_n ? state_q : S_FETCH;
   end

   // datapath control decode
   always_comb begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = SRCB_REG;
      ALUOp       = ALUOP_ADD;
      PCSource    = PCSRC_ALU;
      retire      = 1'b0;
      illegal     = 1'b0;
      case (state_dec)
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = SRCB_FOUR;
            IRWrite = mem_ready & en;
            PCWrite = mem_ready & en;
         end
         S_DECODE: begin
            ALUSrcB = SRCB_IMM_SH;
         end
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
         end
         S_MEMRD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
         end
         S_MEMWB: begin
            RegWrite = 1'b1;
            retire   = 1'b1;
         end
         S_MEMWR: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
            retire   = mem_ready;
         end
         S_EXEC: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_REG;
            ALUOp   = ALUOP_FUNCT;
         end
         S_RWB: begin
            RegDst   = 1'b1;
            MemtoReg = 1'b1;
            RegWrite = 1'b1;
            retire   = 1'b1;
         end
         S_IEXEC: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
            ALUOp   = (Op == OP_SUBI) ? ALUOP_SUB : ALUOP_ADD;
         end
         S_IWB: begin
            MemtoReg = 1'b1;
            RegWrite = 1'b1;
            retire   = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA     = 1'b1;
            ALUSrcB     = SRCB_REG;
            ALUOp       = ALUOP_SUB;
            PCWriteCond = 1'b1;
            PCSource    = PCSRC_ALUOUT;
            retire      = 1'b1;
         end
         S_JUMP: begin
            PCWrite  = 1'b1;
            PCSource = PCSRC_JUMP;
            retire   = 1'b1;
         end
         S_TRAP: begin
            illegal = 1'b1;
         end
         default: ;
      endcase
   end

   assign state_o     = state_q;
   assign instr_count = instr_count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control. A second instance with a 4-bit
// counter is driven in parallel to exercise counter wrap in few cycles.
module tb_multicycle_control;

   logic        clk = 1'b0;
   logic        rst_n, en, mem_ready;
   logic [5:0]  Op;

   logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
   logic        MemtoReg, RegDst, RegWrite, ALUSrcA, retire, illegal;
   logic [1:0]  ALUSrcB, PCSource;
   logic [2:0]  ALUOp;
   logic [3:0]  state_o;
   logic [15:0] instr_count;

   logic        w_PCWrite, w_PCWriteCond, w_IorD, w_MemRead, w_MemWrite, w_IRWrite;
   logic        w_MemtoReg, w_RegDst, w_RegWrite, w_ALUSrcA, w_retire, w_illegal;
   logic [1:0]  w_ALUSrcB, w_PCSource;
   logic [2:0]  w_ALUOp;
   logic [3:0]  w_state_o;
   logic [3:0]  w_instr_count;

   int tests = 0;
   int fails = 0;

   localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3,
                          MEMWB = 4'd4, MEMWR = 4'd5, EXEC = 4'd6, RWB = 4'd7,
                          IEXEC = 4'd8, IWB = 4'd9, BRANCH = 4'd10, JUMP = 4'd11,
                          TRAP = 4'd12;

   always #5 clk = ~clk;

   multicycle_control #(.CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .Op(Op), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
      .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
      .PCSource(PCSource), .retire(retire), .illegal(illegal), .state_o(state_o),
      .instr_count(instr_count)
   );

   multicycle_control #(.CNT_W(4)) dut_w (
      .clk(clk), .rst_n(rst_n), .en(en), .Op(Op), .mem_ready(mem_ready),
      .PCWrite(w_PCWrite), .PCWriteCond(w_PCWriteCond), .IorD(w_IorD), .MemRead(w_MemRead),
      .MemWrite(w_MemWrite), .IRWrite(w_IRWrite), .MemtoReg(w_MemtoReg), .RegDst(w_RegDst),
      .RegWrite(w_RegWrite), .ALUSrcA(w_ALUSrcA), .ALUSrcB(w_ALUSrcB), .ALUOp(w_ALUOp),
      .PCSource(w_PCSource), .retire(w_retire), .illegal(w_illegal), .state_o(w_state_o),
      .instr_count(w_instr_count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b0; mem_ready = 1'b0; Op = 6'd0;
      tick(); tick();
      rst_n = 1'b1; en = 1'b1; mem_ready = 1'b1; Op = 6'd42;
      tick(); tick(); tick();
      mem_ready = 1'b0;
      #1;
      tests++;
      if ({state_o, MemRead, IorD} !== {MEMRD, 1'b1, 1'b1}) begin
         fails++;
         $display("FAIL pre_reset_memrd: state/MemRead/IorD got %h/%b/%b want %h/1/1",
                  state_o, MemRead, IorD, MEMRD);
      end
      rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      #1;
      tests++;
      if ({state_o, instr_count, illegal, MemRead, IorD, PCWrite, IRWrite} !==
          {FETCH, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
         fails++;
         $display("FAIL reset_state: state=%h cnt=%0d ill=%b MemRead=%b IorD=%b PCW=%b IRW=%b",
                  state_o, instr_count, illegal, MemRead, IorD, PCWrite, IRWrite);
      end
   endtask

   task automatic test_lw();
      logic [3:0] exp_seq [5];
      exp_seq = '{FETCH, DECODE, MEMADR, MEMRD, MEMWB};
      en = 1'b1; mem_ready = 1'b1; Op = 6'd42;
      for (int i = 0; i < 5; i++) begin
         #1;
         tests++;
         if (state_o !== exp_seq[i]) begin
            fails++;
            $display("FAIL lw_seq[%0d]: state got %h want %h", i, state_o, exp_seq[i]);
         end
         tick();
      end
      tests++;
      if (state_o !== FETCH || instr_count !== 16'd1) begin
         fails++;
         $display("FAIL lw_done: state=%h cnt=%0d want 0/1", state_o, instr_count);
      end
   endtask

   task automatic test_lw_writeback();
      // run another LW and look closely at the writeback cycle
      en = 1'b1; mem_ready = 1'b1; Op = 6'd42;
      tick(); tick(); tick(); tick();
      #1;
      tests++;
      if ({state_o, RegWrite, MemtoReg, RegDst, retire} !== {MEMWB, 1'b1, 1'b0, 1'b0, 1'b1}) begin
         fails++;
         $display("FAIL lw_wb: state=%h RegWrite=%b MemtoReg=%b RegDst=%b retire=%b",
                  state_o, RegWrite, MemtoReg, RegDst, retire);
      end
      tick();
      tests++;
      if (instr_count !== 16'd2) begin
         fails++;
         $display("FAIL lw_cnt: got %0d want 2", instr_count);
      end
   endtask

   task automatic test_sw_wait();
      int regw_seen = 0;
      en = 1'b1; mem_ready = 1'b1; Op = 6'd41;
      for (int i = 0; i < 3; i++) begin
         #1;
         if (RegWrite) regw_seen++;
         tick();
      end
      tests++;
      if (state_o !== MEMWR) begin
         fails++;
         $display("FAIL sw_enter: state got %h want %h", state_o, MEMWR);
      end
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         if (RegWrite) regw_seen++;
         tests++;
         if ({state_o, MemWrite, IorD, retire} !== {MEMWR, 1'b1, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL sw_wait[%0d]: state=%h MemWrite=%b IorD=%b retire=%b",
                     i, state_o, MemWrite, IorD, retire);
         end
         tick();
      end
      mem_ready = 1'b1;
      #1;
      if (RegWrite) regw_seen++;
      tests++;
      if ({state_o, MemWrite, IorD, retire} !== {MEMWR, 1'b1, 1'b1, 1'b1}) begin
         fails++;
         $display("FAIL sw_ready: state=%h MemWrite=%b IorD=%b retire=%b",
                  state_o, MemWrite, IorD, retire);
      end
      tick();
      tests++;
      if (state_o !== FETCH || instr_count !== 16'd3 || regw_seen != 0) begin
         fails++;
         $display("FAIL sw_done: state=%h cnt=%0d regwrite_cycles=%0d want 0/3/0",
                  state_o, instr_count, regw_seen);
      end
   endtask

   task automatic test_subi_r();
      en = 1'b1; mem_ready = 1'b1; Op = 6'd40;
      tick(); tick();
      tests++;
      if ({state_o, ALUOp, ALUSrcB, ALUSrcA} !== {IEXEC, 3'd1, 2'b10, 1'b1}) begin
         fails++;
         $display("FAIL subi_exec: state=%h ALUOp=%0d ALUSrcB=%b ALUSrcA=%b",
                  state_o, ALUOp, ALUSrcB, ALUSrcA);
      end
      tick();
      tests++;
      if ({state_o, RegWrite, MemtoReg, RegDst, retire} !== {IWB, 1'b1, 1'b1, 1'b0, 1'b1}) begin
         fails++;
         $display("FAIL subi_wb: state=%h RegWrite=%b MemtoReg=%b RegDst=%b retire=%b",
                  state_o, RegWrite, MemtoReg, RegDst, retire);
      end
      tick();
      Op = 6'd20;
      tick(); tick();
      tests++;
      if ({state_o, ALUOp, ALUSrcB, ALUSrcA} !== {EXEC, 3'd2, 2'b00, 1'b1}) begin
         fails++;
         $display("FAIL r_exec: state=%h ALUOp=%0d ALUSrcB=%b ALUSrcA=%b",
                  state_o, ALUOp, ALUSrcB, ALUSrcA);
      end
      tick();
      tests++;
      if ({state_o, RegDst, MemtoReg, RegWrite, retire} !== {RWB, 1'b1, 1'b1, 1'b1, 1'b1}) begin
         fails++;
         $display("FAIL r_wb: state=%h RegDst=%b MemtoReg=%b RegWrite=%b retire=%b",
                  state_o, RegDst, MemtoReg, RegWrite, retire);
      end
      tick();
      tests++;
      if (state_o !== FETCH || instr_count !== 16'd5) begin
         fails++;
         $display("FAIL subi_r_cnt: state=%h cnt=%0d want 0/5", state_o, instr_count);
      end
   endtask

   task automatic test_addi();
      en = 1'b1; mem_ready = 1'b1; Op = 6'd39;
      tick(); tick();
      tests++;
      if ({state_o, ALUOp, ALUSrcB} !== {IEXEC, 3'd0, 2'b10}) begin
         fails++;
         $display("FAIL addi_exec: state=%h ALUOp=%0d ALUSrcB=%b", state_o, ALUOp, ALUSrcB);
      end
      tick(); tick();
   endtask

   task automatic test_beq_j();
      en = 1'b1; mem_ready = 1'b1; Op = 6'd25;
      tick();
      tests++;
      if ({state_o, ALUSrcB, ALUOp} !== {DECODE, 2'b11, 3'd0}) begin
         fails++;
         $display("FAIL decode_out: state=%h ALUSrcB=%b ALUOp=%0d", state_o, ALUSrcB, ALUOp);
      end
      tick();
      tests++;
      if ({state_o, PCWriteCond, PCSource, ALUOp, PCWrite, retire} !==
          {BRANCH, 1'b1, 2'b01, 3'd1, 1'b0, 1'b1}) begin
         fails++;
         $display("FAIL beq: state=%h PCWC=%b PCSrc=%b ALUOp=%0d PCW=%b retire=%b",
                  state_o, PCWriteCond, PCSource, ALUOp, PCWrite, retire);
      end
      tick();
      Op = 6'd26;
      tick(); tick();
      tests++;
      if ({state_o, PCWrite, PCSource, PCWriteCond, retire} !==
          {JUMP, 1'b1, 2'b10, 1'b0, 1'b1}) begin
         fails++;
         $display("FAIL jump: state=%h PCW=%b PCSrc=%b PCWC=%b retire=%b",
                  state_o, PCWrite, PCSource, PCWriteCond, retire);
      end
      tick();
      tests++;
      if (state_o !== FETCH || instr_count !== 16'd8) begin
         fails++;
         $display("FAIL beq_j_cnt: state=%h cnt=%0d want 0/8", state_o, instr_count);
      end
   endtask

   task automatic test_en_low();
      en = 1'b0; mem_ready = 1'b1; Op = 6'd26;
      #1;
      tests++;
      if ({MemRead, PCWrite, IRWrite} !== 3'b100) begin
         fails++;
         $display("FAIL en_low_out: MemRead=%b PCW=%b IRW=%b want 1/0/0", MemRead, PCWrite, IRWrite);
      end
      tick(); tick();
      tests++;
      if (state_o !== FETCH) begin
         fails++;
         $display("FAIL en_low_hold: state got %h want %h", state_o, FETCH);
      end
      en = 1'b1;
      #1;
      tests++;
      if ({MemRead, PCWrite, IRWrite} !== 3'b111) begin
         fails++;
         $display("FAIL en_high_out: MemRead=%b PCW=%b IRW=%b want 1/1/1", MemRead, PCWrite, IRWrite);
      end
   endtask

   task automatic test_trap();
      en = 1'b1; mem_ready = 1'b1; Op = 6'd63;
      tick(); tick();
      for (int i = 0; i < 10; i++) begin
         mem_ready = i[0];
         Op = 6'(i);
         #1;
         tests++;
         if ({state_o, illegal, PCWrite, PCWriteCond, MemWrite, RegWrite, IRWrite, MemRead, retire} !==
             {TRAP, 8'b1000_0000} || instr_count !== 16'd8) begin
            fails++;
            $display("FAIL trap[%0d]: state=%h ill=%b PCW=%b PCWC=%b MW=%b RW=%b IRW=%b MR=%b ret=%b cnt=%0d",
                     i, state_o, illegal, PCWrite, PCWriteCond, MemWrite, RegWrite, IRWrite,
                     MemRead, retire, instr_count);
         end
         tick();
      end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
      tests++;
      if ({state_o, illegal, instr_count, w_instr_count} !== {FETCH, 1'b0, 16'd0, 4'd0}) begin
         fails++;
         $display("FAIL trap_exit: state=%h ill=%b cnt=%0d wcnt=%0d", state_o, illegal,
                  instr_count, w_instr_count);
      end
   endtask

   task automatic test_wrap();
      en = 1'b1; mem_ready = 1'b1; Op = 6'd26;
      for (int k = 0; k < 16; k++) begin
         tick(); tick(); tick();
         if (k == 14) begin
            tests++;
            if (w_instr_count !== 4'd15) begin
               fails++;
               $display("FAIL wrap_max: got %0d want 15", w_instr_count);
            end
         end
      end
      tests++;
      if ({w_instr_count, instr_count, w_state_o} !== {4'd0, 16'd16, FETCH}) begin
         fails++;
         $display("FAIL wrap_zero: wcnt=%0d cnt=%0d wstate=%h want 0/16/0",
                  w_instr_count, instr_count, w_state_o);
      end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_lw_writeback();
      test_sw_wait();
      test_subi_r();
      test_addi();
      test_beq_j();
      test_en_low();
      test_trap();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle sequencer for the processor datapath. It replaces the single-cycle decoder with a state machine that splits each instruction into fetch, decode, execute, memory and writeback steps.
- The datapath is shared across steps: one ALU and one unified instruction/data memory.
- It drives all mux selects and write enables, waits on a memory ready handshake, and counts retired instructions.
- It sits between the instruction register (which supplies Op) and the datapath.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.
- OP_R, 20, R-type opcode. OP_ADDI, 39. OP_SUBI, 40. OP_SW, 41. OP_LW, 42. OP_BEQ, 25. OP_J, 26.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- en  in  1  run enable; sampled only when leaving FETCH.
- Op  in  6  opcode from IR; valid from DECODE onward.
- mem_ready  in  1  memory completes the current read or write this cycle.
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA  out  1 each  datapath controls.
- ALUSrcB  out  2  00 = reg B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2.
- ALUOp  out  3  0 = add, 1 = sub, 2 = use funct.
- PCSource  out  2  00 = ALU result, 01 = ALUOut (branch target), 10 = jump target.
- retire  out  1  one-cycle pulse in the last state of each instruction.
- illegal  out  1  high while in TRAP.
- state_o  out  4  current state encoding, for debug.
- instr_count  out  CNT_W  number of retired instructions.

Behaviour:
- Reset: when rst_n is low at an edge, the next state is FETCH, instr_count is 0, and illegal is 0.
  - Reset wins over every transition, including mid-memory-access.
  - While in the reset state all outputs follow FETCH decode, but PCWrite and IRWrite additionally require en.
- Output decoding:
  - State is registered.
  - Outputs are a combinational decode of the state. The exception is the Mealy terms qualified by mem_ready or en listed below.
  - Any output not listed for a state is 0.
- States and outputs:
  - FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=0, PCSource=00. IRWrite=PCWrite=mem_ready&en. Go to DECODE when mem_ready&en; otherwise stay.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=0 (branch target into ALUOut). Next state by Op:
    - LW or SW: MEMADR
    - R: EXEC
    - ADDI or SUBI: IEXEC
    - BEQ: BRANCH
    - J: JUMP
    - anything else: TRAP
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=0. Next state is MEMRD for LW, MEMWR for SW.
  - MEMRD: MemRead=1, IorD=1. Stay until mem_ready, then go to MEMWB.
  - MEMWB: RegDst=0, MemtoReg=0 (memory data), RegWrite=1, retire=1. Next state FETCH.
  - MEMWR: MemWrite=1, IorD=1. Stay until mem_ready. retire=mem_ready. Then go to FETCH.
  - EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=2. Next state RWB.
  - RWB: RegDst=1, MemtoReg=1 (ALU result), RegWrite=1, retire=1. Next state FETCH.
  - IEXEC: ALUSrcA=1, ALUSrcB=10. ALUOp=0 for ADDI, 1 for SUBI. Next state IWB.
  - IWB: RegDst=0, MemtoReg=1, RegWrite=1, retire=1. Next state FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=1, PCWriteCond=1, PCSource=01, retire=1. Next state FETCH.
  - JUMP: PCWrite=1, PCSource=10, retire=1. Next state FETCH.
  - TRAP: illegal=1, all other outputs 0. Stays in TRAP until reset.
- Latency, assuming mem_ready returns the same cycle it is requested:
  - LW: 5 cycles.
  - SW, R-type, ADDI, SUBI: 4 cycles.
  - BEQ, J: 3 cycles.
  - Each cycle of mem_ready low adds one cycle to FETCH, MEMRD or MEMWR.
- Handshake:
  - MemRead and MemWrite stay asserted, and IorD stays stable, for every cycle until mem_ready.
  - mem_ready outside FETCH, MEMRD and MEMWR is ignored.
- en low in FETCH: the machine stays in FETCH and still asserts MemRead, but PCWrite and IRWrite stay 0.
- instr_count: increments by 1 on every edge where retire=1; wraps from 2^CNT_W-1 to 0.
- Op changing outside DECODE, MEMADR and IEXEC has no effect.
- Unused state encodings go to FETCH on the next edge.

Decomposition:
- Shared package mc_pkg:
  - opcode localparams
  - state enumeration (4-bit)
  - ALUOp codes (ADD=0, SUB=1, FUNCT=2)
  - ALUSrcB codes
  - PCSource codes
- Sub-module mc_next_state: combinational next-state function of (state, Op, mem_ready, en).
- Output decode and counter stay in the top level.

Test Plan:
- rst_n=0 for 2 cycles mid-MEMRD, then release -> state_o=FETCH, instr_count=0, MemRead=1, IorD=0.
- Op=42 (LW), mem_ready always 1 -> state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB; RegWrite=1 with MemtoReg=0 and RegDst=0 in cycle 5; instr_count=1.
- Op=41 (SW), mem_ready held low 3 cycles in MEMWR -> MemWrite=1 and IorD=1 for 4 cycles; RegWrite never 1; retire on the mem_ready cycle only.
- Op=40 (SUBI), then 20 (R-type) -> IEXEC shows ALUOp=1, ALUSrcB=10; EXEC shows ALUOp=2, ALUSrcB=00; RWB shows RegDst=1; instr_count=2 after 8 cycles.
- Op=25 (BEQ), then 26 (J) -> BRANCH: PCWriteCond=1, PCSource=01, ALUOp=1; JUMP: PCWrite=1, PCSource=10; 3 cycles each.
- Op=63 -> TRAP, illegal=1, held for 10 cycles with all writes 0, and instr_count unchanged. Separately, preset instr_count to 0xFFFF and retire once -> instr_count=0.
